eth_tx_link_mux: RTL

Transmit-side link steering between the shared IP-stack transmit arbiter output and the two per-link transmit elastic buffers (10GBASE-R SFP+ and 1000BASE-T RGMII). It is the frame-aware counterpart of the receive-side link mux and replaces combinational push-flag gating. It locks each frame to exactly one link from start to end, so a frame is never split across links. If a link drops mid-frame, it aborts that frame cleanly with a drop, and it enforces a settle hold-off after every link-selection change.

---
 rtl/eth_tx_link_mux.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/eth_tx_link_mux.sv
// Transmit link steering: locks each frame to one of the 10G/1G elastic buffers, aborts
// cleanly on link loss, and holds off new frames after every preferred-link change.
package eth_tx_link_mux_pkg;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic        commit;
    logic        drop;
    logic [63:0] data;
    logic [3:0]  bytes_valid;
    logic [47:0] dst_mac;
    logic [15:0] ethertype;
  } EthernetTxL2Bus;

endpackage

module eth_tx_link_mux
  import eth_tx_link_mux_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned COUNTER_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     baser_link_up,
  input  logic                     baset_link_up,
  input  EthernetTxL2Bus           tx_l2_bus,
  output EthernetTxL2Bus           tx_baser_l2_bus,
  output EthernetTxL2Bus           tx_baset_l2_bus,
  output logic [1:0]               active_port,
  output logic [COUNTER_WIDTH-1:0] perf_baser_frames,
  output logic [COUNTER_WIDTH-1:0] perf_baset_frames,
  output logic [COUNTER_WIDTH-1:0] perf_dropped_frames
);

  localparam int unsigned HoldoffWidth = $clog2(HOLDOFF_CYCLES + 2);
  localparam logic [HoldoffWidth-1:0] HoldoffLoad = HoldoffWidth'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {StIdle, StFwdR, StFwdT, StDiscard} state_e;

  state_e                  state_q;
  logic                    discard_cnt_q;
  logic [HoldoffWidth-1:0] holdoff_q;
  logic [1:0]              pref_prev_q;

  logic [1:0]     pref;
  logic [3:0]     ctl_in;
  logic [3:0]     ctl_out;
  logic           lock_up;
  logic           in_fwd;
  logic           abort;
  logic           admit;
  logic           admit_r;
  logic           admit_t;
  EthernetTxL2Bus pass_bus;
  EthernetTxL2Bus baser_d;
  EthernetTxL2Bus baset_d;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    pref = baser_link_up ? 2'b10 : (baset_link_up ? 2'b01 : 2'b00);

    pass_bus            = tx_l2_bus;
    pass_bus.start      = 1'b0;
    pass_bus.data_valid = 1'b0;
    pass_bus.commit     = 1'b0;
    pass_bus.drop       = 1'b0;

    ctl_in  = {tx_l2_bus.start, tx_l2_bus.data_valid, tx_l2_bus.commit, tx_l2_bus.drop};
    lock_up = (state_q == StFwdR) ? baser_link_up : baset_link_up;
    in_fwd  = (state_q == StFwdR) || (state_q == StFwdT);
    // A start inside an open frame means the previous frame lost its commit.
    abort   = in_fwd && (!lock_up || tx_l2_bus.start);
    admit   = (state_q == StIdle) && tx_l2_bus.start && (holdoff_q == '0);
    admit_r = admit && (active_port == 2'b10);
    admit_t = admit && (active_port == 2'b01);
    ctl_out = abort ? 4'b0001 : ctl_in;

    baser_d = pass_bus;
    baset_d = pass_bus;
    if (admit_r || (state_q == StFwdR)) begin
      {baser_d.start, baser_d.data_valid, baser_d.commit, baser_d.drop} = ctl_out;
    end
    if (admit_t || (state_q == StFwdT)) begin
      {baset_d.start, baset_d.data_valid, baset_d.commit, baset_d.drop} = ctl_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= StIdle;
      discard_cnt_q       <= 1'b0;
      holdoff_q           <= HoldoffLoad;
      pref_prev_q         <= 2'b00;
      active_port         <= 2'b00;
      tx_baser_l2_bus     <= '0;
      tx_baset_l2_bus     <= '0;
      perf_baser_frames   <= '0;
      perf_baset_frames   <= '0;
      perf_dropped_frames <= '0;
    end else begin
      active_port     <= pref;
      pref_prev_q     <= active_port;
      tx_baser_l2_bus <= baser_d;
      tx_baset_l2_bus <= baset_d;

      if (active_port != pref_prev_q) begin
        holdoff_q <= HoldoffLoad;
      end else if (holdoff_q != '0) begin
        holdoff_q <= holdoff_q - 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (tx_l2_bus.start) begin
            if (admit_r) begin
              state_q <= StFwdR;
            end else if (admit_t) begin
              state_q <= StFwdT;
            end else begin
              state_q             <= StDiscard;
              discard_cnt_q       <= 1'b0;
              perf_dropped_frames <= sat_inc(perf_dropped_frames);
            end
          end
        end
        StFwdR, StFwdT: begin
          if (abort) begin
            state_q             <= StDiscard;
            // The frame that caused the abort is counted when it closes.
            discard_cnt_q       <= tx_l2_bus.start;
            perf_dropped_frames <= sat_inc(perf_dropped_frames);
          end else if (tx_l2_bus.commit) begin
            state_q <= StIdle;
            if (state_q == StFwdR) begin
              perf_baser_frames <= sat_inc(perf_baser_frames);
            end else begin
              perf_baset_frames <= sat_inc(perf_baset_frames);
            end
          end else if (tx_l2_bus.drop) begin
            state_q <= StIdle;
          end
        end
        StDiscard: begin
          if (tx_l2_bus.commit || tx_l2_bus.drop) begin
            state_q       <= StIdle;
            discard_cnt_q <= 1'b0;
            if (discard_cnt_q) begin
              perf_dropped_frames <= sat_inc(perf_dropped_frames);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
